// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - memory-mapped 4-digit 7-segment refresh scheduler
// Defining SEG_IRQ_EN adds the sticky frame flag, CTRL.IRQ_EN and the irq output.
module seg_scan_controller #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
  parameter int unsigned SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        irq
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [11:0]      raw_q, raw_d;
  logic [15:0]      value_q, value_d;
  logic [3:0]       blank_q, blank_d;
  logic [DIV_W-1:0] div_cnt_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       frame_q, frame_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       digit;

  logic       sel, wr_raw, wr_value, wr_ctrl, tc, wrap;
  logic [1:0] off;
  logic       unused_bits;

  assign sel      = (Address[31:4] == BASE_ADDR[31:4]);
  assign off      = Address[3:2];
  assign wr_raw   = MemWrite && sel && (off == 2'd0);
  assign wr_value = MemWrite && sel && (off == 2'd1);
  assign wr_ctrl  = MemWrite && sel && (off == 2'd2);
  // A CTRL write restarts the scan, so it overrides a coincident terminal count.
  assign tc       = (state_q == SCAN) && !wr_ctrl && (div_cnt_q == DIV_LAST);
  assign wrap     = tc && (idx_q == 2'd3);
  assign unused_bits = ^{Address[1:0], WriteData[31:16]};

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: seg_decode = 7'h3f;  4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5b;  4'h3: seg_decode = 7'h4f;
      4'h4: seg_decode = 7'h66;  4'h5: seg_decode = 7'h6d;
      4'h6: seg_decode = 7'h7d;  4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7f;  4'h9: seg_decode = 7'h6f;
      4'ha: seg_decode = 7'h77;  4'hb: seg_decode = 7'h7c;
      4'hc: seg_decode = 7'h58;  4'hd: seg_decode = 7'h5e;
      4'he: seg_decode = 7'h79;  default: seg_decode = 7'h71;
    endcase
  endfunction

`ifdef SEG_IRQ_EN
  logic irq_en_q, flag_q, irq_q, wr_status;
  assign wr_status = MemWrite && sel && (off == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= WriteData[1];
      if (wrap) flag_q <= 1'b1;
      else if (wr_status && WriteData[8]) flag_q <= 1'b0;
      irq_q <= flag_q & irq_en_q;
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MANUAL;
      raw_q     <= '0;
      value_q   <= '0;
      blank_q   <= '0;
      div_cnt_q <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      an_q      <= '0;
      seg_q     <= '0;
    end else begin
      state_q   <= state_d;
      raw_q     <= raw_d;
      value_q   <= value_d;
      blank_q   <= blank_d;
      div_cnt_q <= div_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    raw_d   = raw_q;
    value_d = value_q;
    blank_d = blank_q;
    div_d   = div_cnt_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    if (wr_raw)   raw_d   = WriteData[11:0];
    if (wr_value) value_d = WriteData[15:0];
    if (wr_ctrl) begin
      state_d = WriteData[0] ? SCAN : MANUAL;
      blank_d = WriteData[7:4];
    end
    case (state_q)
      SCAN: begin
        if (wr_ctrl) begin
          div_d = '0;
          idx_d = '0;
        end else if (tc) begin
          div_d = '0;
          idx_d = idx_q + 2'd1;
          if (wrap) frame_d = frame_q + 8'd1;
        end else begin
          div_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        div_d = '0;
        idx_d = '0;
      end
    endcase
  end

  // Outputs are a registered view of the committed state, one cycle behind writes.
  always_comb begin
    digit = 4'(value_q >> {idx_q, 2'b00});
    an_d  = raw_q[11:8];
    seg_d = raw_q[6:0];
    if (state_q == SCAN) begin
      an_d  = (4'b0001 << idx_q) & ~blank_q;
      seg_d = blank_q[idx_q] ? 7'h00 : seg_decode(digit);
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

  always_comb begin
    ReadData = '0;
    if (MemRead && sel) begin
      case (off)
        2'd0: ReadData[11:0] = raw_q;
        2'd1: ReadData[15:0] = value_q;
        2'd2: begin
          ReadData[0]   = (state_q == SCAN);
          ReadData[7:4] = blank_q;
`ifdef SEG_IRQ_EN
          ReadData[1]   = irq_en_q;
`endif
        end
        default: begin
          ReadData[1:0]   = idx_q;
          ReadData[23:16] = frame_q;
`ifdef SEG_IRQ_EN
          ReadData[8]     = flag_q;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - directed self-checking bench for seg_scan_controller
module tb_seg_scan_controller;
  localparam logic [31:0] BASE = 32'h0000_4000;
`ifdef SEG_IRQ_EN
  localparam logic [31:0] IRQ_BUILD = 32'd1;
`else
  localparam logic [31:0] IRQ_BUILD = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        irq;
  logic [31:0] rd;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] scan_an   [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic [6:0] scan_seg  [4] = '{7'h58, 7'h6d, 7'h77, 7'h4f};
  logic [3:0] blank_an  [4] = '{4'h0, 4'h2, 4'h0, 4'h8};
  logic [6:0] blank_seg [4] = '{7'h00, 7'h6d, 7'h00, 7'h4f};

  always #5 clk = ~clk;

  seg_scan_controller #(.BASE_ADDR(BASE), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .an(an), .seg(seg), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Address = addr; WriteData = data; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    Address = addr; MemRead = 1'b1;
    #1 data = ReadData;
    MemRead = 1'b0;
  endtask

  initial begin
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'h0);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 32'(4 * i), rd);
      check($sformatf("rst_rd%0d", i), rd, 32'h0);
    end

    // Manual mode and write latency
    bus_write(BASE, 32'h0000_0f71);
    check("raw_lat0_an", 32'(an), 32'h0);
    @(negedge clk);
    check("raw_an", 32'(an), 32'hf);
    check("raw_seg", 32'(seg), 32'h71);
    bus_read(BASE, rd);
    check("raw_rd", rd, 32'h0000_0f71);
    Address = BASE; WriteData = 32'hffff_0abc; MemWrite = 1'b1; MemRead = 1'b1;
    #1 check("rd_during_wr", ReadData, 32'h0000_0f71);
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    bus_read(BASE, rd);
    check("raw_mask_rd", rd, 32'h0000_0abc);
    bus_write(BASE, 32'h0000_0f71);

    // Unmapped offset, deselected read, CTRL bit1 visibility
    bus_write(BASE + 32'h10, 32'hffff_ffff);
    bus_read(BASE + 32'h10, rd);
    check("unmapped_rd", rd, 32'h0);
    bus_read(BASE, rd);
    check("raw_after_unmapped", rd, 32'h0000_0f71);
    Address = BASE; MemRead = 1'b0;
    #1 check("no_memread", ReadData, 32'h0);
    bus_write(BASE + 32'h8, 32'h0000_0002);
    bus_read(BASE + 32'h8, rd);
    check("ctrl_bit1", rd, IRQ_BUILD << 1);
    bus_write(BASE + 32'h8, 32'h0);

    // Scanning: each digit held 4 cycles
    bus_write(BASE + 32'h4, 32'h0000_3a5c);
    bus_write(BASE + 32'h8, 32'h1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("scan_an_c%0d", k), 32'(an), 32'(scan_an[k / 4]));
      check($sformatf("scan_seg_c%0d", k), 32'(seg), 32'(scan_seg[k / 4]));
    end
    bus_read(BASE + 32'hc, rd);
    check("status_frame1", rd, 32'h0001_0000);

    // Blanking digits 0 and 2
    bus_write(BASE + 32'h8, 32'h51);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("blank_an_c%0d", k), 32'(an), 32'(blank_an[k / 4]));
      check($sformatf("blank_seg_c%0d", k), 32'(seg), 32'(blank_seg[k / 4]));
    end

    // CTRL write on the terminal-count edge restarts at digit 0
    bus_write(BASE + 32'h8, 32'h1);
    repeat (3) @(negedge clk);
    bus_write(BASE + 32'h8, 32'h1);
    bus_read(BASE + 32'hc, rd);
    check("coll_idx", rd & 32'h3, 32'h0);
    @(negedge clk);
    check("coll_an", 32'(an), 32'h1);
    repeat (4) @(negedge clk);
    check("coll_adv_an", 32'(an), 32'h2);

    // VALUE write coincident with an idx advance: both apply
    repeat (2) @(negedge clk);
    bus_write(BASE + 32'h4, 32'h0000_1234);
    @(negedge clk);
    check("valadv_an", 32'(an), 32'h4);
    check("valadv_seg", 32'(seg), 32'h5b);

    // AUTO cleared mid-scan reverts to RAW next cycle
    bus_write(BASE + 32'h8, 32'h0);
    check("man_lat0_an", 32'(an), 32'h4);
    @(negedge clk);
    check("man_an", 32'(an), 32'hf);
    check("man_seg", 32'(seg), 32'h71);
    bus_read(BASE + 32'hc, rd);
    check("man_idx", rd & 32'h3, 32'h0);

    // Asynchronous mid-operation reset
    bus_write(BASE + 32'h8, 32'h1);
    @(negedge clk);
    check("pre_rst_an", 32'(an), 32'h1);
    #2 reset = 1'b0;
    #1 check("mid_rst_an", 32'(an), 32'h0);
    check("mid_rst_seg", 32'(seg), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    bus_read(BASE + 32'hc, rd);
    check("post_rst_status", rd, 32'h0);
    bus_read(BASE + 32'h4, rd);
    check("post_rst_value", rd, 32'h0);

    // Frame flag / interrupt (constant 0 unless the feature is built in)
    @(negedge clk);
    bus_write(BASE + 32'h8, 32'h3);
    repeat (16) @(negedge clk);
    check("irq_before", 32'(irq), 32'h0);
    bus_read(BASE + 32'hc, rd);
    check("flag_set", (rd >> 8) & 32'h1, IRQ_BUILD);
    @(negedge clk);
    check("irq_rise", 32'(irq), IRQ_BUILD);
`ifdef SEG_IRQ_EN
    bus_write(BASE + 32'hc, 32'h100);
    check("irq_hold", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'h0);
    bus_read(BASE + 32'hc, rd);
    check("flag_clr", (rd >> 8) & 32'h1, 32'h0);
    repeat (12) @(negedge clk);
    bus_write(BASE + 32'hc, 32'h100);
    bus_read(BASE + 32'hc, rd);
    check("flag_set_wins", (rd >> 8) & 32'h1, 32'h1);
    @(negedge clk);
    check("irq_set_wins", 32'(irq), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
